// File: rtl/branch_resolve_unit_pkg.sv
// ---------------------------------------------------------------------------
// branch_pkg
// Shared types and constants for the branch resolve unit: the branch
// condition encoding, the predictor counter type, its reset value, the
// instruction size used for fall-through PCs, and a helper that tells
// conditional from unconditional branch selects.
// ---------------------------------------------------------------------------
package branch_pkg;

  typedef enum logic [2:0] {
    BR_EQ     = 3'b000,
    BR_NE     = 3'b001,
    BR_ALWAYS = 3'b010,
    BR_GEU    = 3'b011,
    BR_LT     = 3'b100,
    BR_GE     = 3'b101,
    BR_LTU    = 3'b110,
    BR_NEVER  = 3'b111
  } br_sel_e;

  typedef logic [1:0] bht_ctr_t;

  // Weakly not-taken: one taken outcome flips the prediction.
  localparam bht_ctr_t CTR_RESET  = 2'b01;
  localparam int       INSN_BYTES = 4;

  function automatic logic is_conditional(input br_sel_e sel);
    return (sel != BR_ALWAYS) && (sel != BR_NEVER);
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit_if
// Request/result handshake bundle between execute and the branch resolve
// unit.
//   master : drives in_* request fields and out_ready; sees in_ready/out_*
//   slave  : the resolve unit
// Request : in_valid/in_ready, in_pc, in_a, in_b, in_br_sel, in_pred_taken,
//           in_target
// Result  : out_valid/out_ready, out_taken, out_mispredict, out_redirect_pc
// ---------------------------------------------------------------------------
interface branch_resolve_unit_if #(
  parameter int XLEN = 32
);
  import branch_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  br_sel_e         in_br_sel;
  logic            in_pred_taken;
  logic [XLEN-1:0] in_target;

  logic            out_valid;
  logic            out_ready;
  logic            out_taken;
  logic            out_mispredict;
  logic [XLEN-1:0] out_redirect_pc;

  modport master (
    output in_valid, in_pc, in_a, in_b, in_br_sel, in_pred_taken, in_target,
    output out_ready,
    input  in_ready,
    input  out_valid, out_taken, out_mispredict, out_redirect_pc
  );

  modport slave (
    input  in_valid, in_pc, in_a, in_b, in_br_sel, in_pred_taken, in_target,
    input  out_ready,
    output in_ready,
    output out_valid, out_taken, out_mispredict, out_redirect_pc
  );

endinterface

// File: rtl/branch_resolve_unit_cond_eval.sv
// ---------------------------------------------------------------------------
// branch_cond_eval
// Purely combinational branch condition evaluator on full-width operands.
//   i_a, i_b  : XLEN-bit operands (rs1, rs2)
//   i_br_sel  : condition select
//   o_taken   : 1 when the selected condition holds
// ---------------------------------------------------------------------------
module branch_cond_eval
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  input  br_sel_e         i_br_sel,
  output logic            o_taken
);

  // Direct relational compares: no subtract, so no borrow/overflow corner cases.
  always_comb begin
    o_taken = 1'b0;
    case (i_br_sel)
      BR_EQ:     o_taken = (i_a == i_b);
      BR_NE:     o_taken = (i_a != i_b);
      BR_LT:     o_taken = ($signed(i_a) <  $signed(i_b));
      BR_GE:     o_taken = ($signed(i_a) >= $signed(i_b));
      BR_LTU:    o_taken = (i_a <  i_b);
      BR_GEU:    o_taken = (i_a >= i_b);
      BR_ALWAYS: o_taken = 1'b1;
      BR_NEVER:  o_taken = 1'b0;
      default:   o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
// Resolves branches behind a valid/ready handshake, optionally registering
// the result (PIPE=1) or passing it straight through (PIPE=0). Holds a
// PC-indexed bimodal predictor (2-bit saturating counters) and counts
// resolved / mispredicted conditional branches.
//   clk, rst          : clock, async active-high reset
//   lookup_pc         : fetch-side PC; lookup_taken = counter MSB at that PC
//   flush             : kills the pending result and blocks accept this cycle
//   branch_count      : conditional branches accepted (wraps)
//   mispredict_count  : mispredicted conditional branches accepted (wraps)
//   bus               : request/result handshake (slave side)
// ---------------------------------------------------------------------------
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int PIPE        = 1,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [XLEN-1:0]    lookup_pc,
  output logic               lookup_taken,
  input  logic               flush,
  output logic [CNT_W-1:0]   branch_count,
  output logic [CNT_W-1:0]   mispredict_count,
  branch_resolve_unit_if.slave bus
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic            w_taken;
  logic            w_mispredict;
  logic            w_cond;
  logic            w_accept;
  logic [XLEN-1:0] w_redirect_pc;
  logic [IDX_W-1:0] w_upd_idx;
  logic [IDX_W-1:0] w_lkp_idx;
  logic            w_unused_lookup_bits;

  bht_ctr_t        r_bht [BHT_ENTRIES];
  logic [CNT_W-1:0] r_branch_count;
  logic [CNT_W-1:0] r_mispredict_count;

  branch_cond_eval #(.XLEN(XLEN)) u_cond_eval (
    .i_a      (bus.in_a),
    .i_b      (bus.in_b),
    .i_br_sel (bus.in_br_sel),
    .o_taken  (w_taken)
  );

  assign w_mispredict  = w_taken ^ bus.in_pred_taken;
  assign w_redirect_pc = w_taken ? bus.in_target : bus.in_pc + XLEN'(INSN_BYTES);
  assign w_cond        = is_conditional(bus.in_br_sel);

  // Word-aligned PCs: drop the byte offset bits before indexing.
  assign w_upd_idx = bus.in_pc[IDX_W+1:2];
  assign w_lkp_idx = lookup_pc[IDX_W+1:2];
  assign w_unused_lookup_bits = ^{lookup_pc[XLEN-1:IDX_W+2], lookup_pc[1:0]};

  generate
    if (PIPE != 0) begin : g_pipe
      logic            r_valid;
      logic            r_taken;
      logic            r_mispredict;
      logic [XLEN-1:0] r_redirect_pc;

      assign bus.in_ready = ~r_valid | bus.out_ready;
      assign w_accept     = bus.in_valid & bus.in_ready & ~flush;

      // Payload only loads on accept, so it is frozen while stalled.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_valid       <= 1'b0;
          r_taken       <= 1'b0;
          r_mispredict  <= 1'b0;
          r_redirect_pc <= '0;
        end else if (flush) begin
          r_valid <= 1'b0;
        end else if (w_accept) begin
          r_valid       <= 1'b1;
          r_taken       <= w_taken;
          r_mispredict  <= w_mispredict;
          r_redirect_pc <= w_redirect_pc;
        end else if (bus.out_ready) begin
          r_valid <= 1'b0;
        end
      end

      assign bus.out_valid       = r_valid;
      assign bus.out_taken       = r_taken;
      assign bus.out_mispredict  = r_mispredict;
      assign bus.out_redirect_pc = r_redirect_pc;
    end else begin : g_comb
      assign bus.in_ready = bus.out_ready;
      assign w_accept     = bus.in_valid & bus.out_ready & ~flush;

      // No result register here, so reset has to mask the outputs directly.
      assign bus.out_valid       = bus.in_valid & ~flush & ~rst;
      assign bus.out_taken       = w_taken & ~rst;
      assign bus.out_mispredict  = w_mispredict & ~rst;
      assign bus.out_redirect_pc = rst ? '0 : w_redirect_pc;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= CTR_RESET;
    end else if (w_accept && w_cond) begin
      if (w_taken) begin
        if (r_bht[w_upd_idx] != 2'b11) r_bht[w_upd_idx] <= r_bht[w_upd_idx] + 2'b01;
      end else begin
        if (r_bht[w_upd_idx] != 2'b00) r_bht[w_upd_idx] <= r_bht[w_upd_idx] - 2'b01;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else if (w_accept && w_cond) begin
      r_branch_count <= r_branch_count + CNT_W'(1);
      if (w_mispredict) r_mispredict_count <= r_mispredict_count + CNT_W'(1);
    end
  end

  // Read-before-write: an update in this cycle shows up on the next one.
  assign lookup_taken     = r_bht[w_lkp_idx][1];
  assign branch_count     = r_branch_count;
  assign mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;
  import branch_pkg::*;

  localparam int N_BHT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        t_valid = 1'b0, t_pred = 1'b0, t_flush = 1'b0;
  logic        t_rdy1 = 1'b1, t_rdy0 = 1'b1;
  logic [31:0] t_pc = '0, t_a = '0, t_b = '0, t_target = '0, t_lookup = '0;
  br_sel_e     t_sel = BR_EQ;

  logic        lt1, lt0;
  logic [31:0] bc1, mc1;
  logic [7:0]  bc0, mc0;

  branch_resolve_unit_if #(.XLEN(32)) if1 ();
  branch_resolve_unit_if #(.XLEN(32)) if0 ();

  assign if1.in_valid = t_valid;  assign if0.in_valid = t_valid;
  assign if1.in_pc = t_pc;        assign if0.in_pc = t_pc;
  assign if1.in_a = t_a;          assign if0.in_a = t_a;
  assign if1.in_b = t_b;          assign if0.in_b = t_b;
  assign if1.in_br_sel = t_sel;   assign if0.in_br_sel = t_sel;
  assign if1.in_pred_taken = t_pred; assign if0.in_pred_taken = t_pred;
  assign if1.in_target = t_target;   assign if0.in_target = t_target;
  assign if1.out_ready = t_rdy1;  assign if0.out_ready = t_rdy0;

  branch_resolve_unit #(.XLEN(32), .BHT_ENTRIES(N_BHT), .PIPE(1), .CNT_W(32)) u_p1 (
    .clk(clk), .rst(rst), .lookup_pc(t_lookup), .lookup_taken(lt1), .flush(t_flush),
    .branch_count(bc1), .mispredict_count(mc1), .bus(if1.slave));

  branch_resolve_unit #(.XLEN(32), .BHT_ENTRIES(N_BHT), .PIPE(0), .CNT_W(8)) u_p0 (
    .clk(clk), .rst(rst), .lookup_pc(t_lookup), .lookup_taken(lt0), .flush(t_flush),
    .branch_count(bc0), .mispredict_count(mc0), .bus(if0.slave));

  int n_checks = 0;
  int n_err = 0;

  // Reference model state
  int          m1_bht [N_BHT];
  int          m0_bht [N_BHT];
  bit          m1_valid, m1_taken, m1_mis;
  logic [31:0] m1_redir;
  longint      m1_bc, m1_mc, m0_bc, m0_mc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_taken(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
    longint ua, ub, sa, sb;
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    sa = a[31] ? ua - 64'sh1_0000_0000 : ua;
    sb = b[31] ? ub - 64'sh1_0000_0000 : ub;
    case (sel)
      3'd0: return ua == ub;
      3'd1: return ua != ub;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return ua < ub;
      3'd3: return ua >= ub;
      3'd2: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % N_BHT);
  endfunction

  function automatic int sat(input int v, input bit up);
    if (up) return (v >= 3) ? 3 : v + 1;
    return (v <= 0) ? 0 : v - 1;
  endfunction

  function automatic logic [31:0] pick_op();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_BHT; i++) begin
      m1_bht[i] = 1;
      m0_bht[i] = 1;
    end
    m1_valid = 0; m1_taken = 0; m1_mis = 0; m1_redir = '0;
    m1_bc = 0; m1_mc = 0; m0_bc = 0; m0_mc = 0;
  endtask

  // Inputs are set by the caller just after a rising edge; this checks both
  // DUTs mid-cycle, advances the model, and returns just after the next edge.
  task automatic cycle();
    bit tk, mis, cond, acc1, acc0;
    logic [31:0] redir;
    int ui, li;
    @(negedge clk);
    tk    = ref_taken(t_sel, t_a, t_b);
    mis   = tk ^ t_pred;
    redir = tk ? t_target : t_pc + 32'd4;
    cond  = !(t_sel inside {BR_ALWAYS, BR_NEVER});
    ui    = idx_of(t_pc);
    li    = idx_of(t_lookup);

    chk("p1_out_valid", {63'b0, if1.out_valid}, {63'b0, m1_valid});
    chk("p1_out_taken", {63'b0, if1.out_taken}, {63'b0, m1_taken});
    chk("p1_mispredict", {63'b0, if1.out_mispredict}, {63'b0, m1_mis});
    chk("p1_redirect", {32'b0, if1.out_redirect_pc}, {32'b0, m1_redir});
    chk("p1_in_ready", {63'b0, if1.in_ready}, {63'b0, (!m1_valid || t_rdy1)});
    chk("p1_lookup", {63'b0, lt1}, {63'b0, (m1_bht[li] >= 2)});
    chk("p1_branch_count", {32'b0, bc1}, m1_bc);
    chk("p1_mispred_count", {32'b0, mc1}, m1_mc);

    chk("p0_out_valid", {63'b0, if0.out_valid}, {63'b0, (t_valid && !t_flush)});
    chk("p0_out_taken", {63'b0, if0.out_taken}, {63'b0, tk});
    chk("p0_mispredict", {63'b0, if0.out_mispredict}, {63'b0, mis});
    chk("p0_redirect", {32'b0, if0.out_redirect_pc}, {32'b0, redir});
    chk("p0_in_ready", {63'b0, if0.in_ready}, {63'b0, t_rdy0});
    chk("p0_lookup", {63'b0, lt0}, {63'b0, (m0_bht[li] >= 2)});
    chk("p0_branch_count", {56'b0, bc0}, m0_bc);
    chk("p0_mispred_count", {56'b0, mc0}, m0_mc);

    acc1 = t_valid && (!m1_valid || t_rdy1) && !t_flush;
    acc0 = t_valid && t_rdy0 && !t_flush;
    if (t_flush) m1_valid = 0;
    else if (acc1) begin
      m1_valid = 1; m1_taken = tk; m1_mis = mis; m1_redir = redir;
    end else if (t_rdy1) m1_valid = 0;
    if (acc1 && cond) begin
      m1_bht[ui] = sat(m1_bht[ui], tk);
      m1_bc = (m1_bc + 1) % 64'h1_0000_0000;
      if (mis) m1_mc = (m1_mc + 1) % 64'h1_0000_0000;
    end
    if (acc0 && cond) begin
      m0_bht[ui] = sat(m0_bht[ui], tk);
      m0_bc = (m0_bc + 1) % 256;
      if (mis) m0_mc = (m0_mc + 1) % 256;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input br_sel_e sel, input logic [31:0] pc, input logic [31:0] a,
                         input logic [31:0] b, input logic pred, input logic [31:0] tgt);
    t_valid = 1'b1; t_sel = sel; t_pc = pc; t_a = a; t_b = b; t_pred = pred; t_target = tgt;
  endtask

  initial begin
    longint bc_before;
    model_reset();
    #1;
    chk("rst_out_valid", {63'b0, if1.out_valid}, 64'd0);
    chk("rst_out_taken", {63'b0, if1.out_taken}, 64'd0);
    chk("rst_mispredict", {63'b0, if1.out_mispredict}, 64'd0);
    chk("rst_redirect", {32'b0, if1.out_redirect_pc}, 64'd0);
    chk("rst_bc", {32'b0, bc1}, 64'd0);
    chk("rst_mc", {32'b0, mc1}, 64'd0);
    chk("rst_lookup", {63'b0, lt1}, 64'd0);
    chk("rst_p0_redirect", {32'b0, if0.out_redirect_pc}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // BEQ taken with not-taken prediction
    set_req(BR_EQ, 32'h44, 32'd5, 32'd5, 1'b0, 32'h2000);
    cycle();
    t_valid = 1'b0;
    chk("beq_valid", {63'b0, if1.out_valid}, 64'd1);
    chk("beq_taken", {63'b0, if1.out_taken}, 64'd1);
    chk("beq_mispredict", {63'b0, if1.out_mispredict}, 64'd1);
    chk("beq_redirect", {32'b0, if1.out_redirect_pc}, 64'h2000);
    chk("beq_bc", {32'b0, bc1}, 64'd1);
    chk("beq_mc", {32'b0, mc1}, 64'd1);
    cycle();

    // Signed vs unsigned on 0xFFFFFFFF vs 1 (PIPE=0 shows same-cycle result)
    set_req(BR_LT, 32'h88, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h500);
    #1 chk("blt_taken", {63'b0, if0.out_taken}, 64'd1);
    cycle();
    chk("blt_p1_taken", {63'b0, if1.out_taken}, 64'd1);
    t_sel = BR_LTU;
    #1 chk("bltu_taken", {63'b0, if0.out_taken}, 64'd0);
    cycle();
    t_sel = BR_GEU;
    #1 chk("bgeu_taken", {63'b0, if0.out_taken}, 64'd1);
    cycle();
    t_sel = BR_GE;
    #1 chk("bge_taken", {63'b0, if0.out_taken}, 64'd0);
    cycle();

    // Predictor saturation at pc 0x100
    t_lookup = 32'h100;
    set_req(BR_NE, 32'h100, 32'd1, 32'd2, 1'b0, 32'h900);
    #1 chk("bht_t0", {63'b0, lt1}, 64'd0);
    cycle();
    chk("bht_t1", {63'b0, lt1}, 64'd1);
    cycle();
    chk("bht_t2", {63'b0, lt1}, 64'd1);
    cycle();
    chk("bht_sat_hi", {63'b0, lt0}, 64'd1);
    t_a = 32'd7; t_b = 32'd7;
    for (int i = 0; i < 4; i++) cycle();
    chk("bht_sat_lo_p1", {63'b0, lt1}, 64'd0);
    chk("bht_sat_lo_p0", {63'b0, lt0}, 64'd0);

    // Backpressure then back-to-back
    set_req(BR_ALWAYS, 32'h200, 32'd0, 32'd0, 1'b1, 32'h3000);
    t_rdy1 = 1'b1;
    cycle();
    t_rdy1 = 1'b0;
    set_req(BR_ALWAYS, 32'h204, 32'd0, 32'd0, 1'b1, 32'h3100);
    for (int i = 0; i < 3; i++) cycle();
    chk("bp_in_ready", {63'b0, if1.in_ready}, 64'd0);
    chk("bp_hold_redir", {32'b0, if1.out_redirect_pc}, 64'h3000);
    t_rdy1 = 1'b1;
    cycle();
    chk("b2b_0", {32'b0, if1.out_redirect_pc}, 64'h3100);
    t_target = 32'h3200;
    cycle();
    chk("b2b_1", {32'b0, if1.out_redirect_pc}, 64'h3200);
    t_target = 32'h3300;
    cycle();
    chk("b2b_2", {32'b0, if1.out_redirect_pc}, 64'h3300);

    // Flush with a pending result and a valid request
    t_rdy1 = 1'b0;
    set_req(BR_EQ, 32'h100, 32'd3, 32'd3, 1'b0, 32'h4000);
    t_flush = 1'b1;
    bc_before = m1_bc;
    cycle();
    t_flush = 1'b0;
    t_rdy1 = 1'b1;
    chk("flush_valid", {63'b0, if1.out_valid}, 64'd0);
    chk("flush_bc", {32'b0, bc1}, bc_before);
    chk("flush_bht", {63'b0, lt1}, 64'd0);

    // Unconditional: never counted; fall-through wraps
    bc_before = m1_bc;
    set_req(BR_ALWAYS, 32'h300, 32'd1, 32'd2, 1'b0, 32'h5000);
    cycle();
    chk("always_taken", {63'b0, if1.out_taken}, 64'd1);
    chk("always_mis", {63'b0, if1.out_mispredict}, 64'd1);
    set_req(BR_NEVER, 32'hFFFF_FFFC, 32'd1, 32'd1, 1'b0, 32'h5000);
    cycle();
    chk("never_taken", {63'b0, if1.out_taken}, 64'd0);
    chk("never_wrap", {32'b0, if1.out_redirect_pc}, 64'd0);
    chk("uncond_bc", {32'b0, bc1}, bc_before);

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      t_valid  = ($urandom_range(0, 9) < 7);
      t_flush  = ($urandom_range(0, 9) == 0);
      t_rdy1   = ($urandom_range(0, 3) != 0);
      t_rdy0   = ($urandom_range(0, 3) != 0);
      t_sel    = br_sel_e'(3'($urandom_range(0, 7)));
      t_a      = pick_op();
      t_b      = ($urandom_range(0, 3) == 0) ? t_a : pick_op();
      t_pc     = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : 32'($urandom_range(0, 31)) * 32'd4;
      t_lookup = ($urandom_range(0, 1) == 0) ? t_pc : 32'($urandom_range(0, 31)) * 32'd4;
      t_pred   = 1'($urandom_range(0, 1));
      t_target = $urandom;
      cycle();
    end

    // Async reset while a result is pending
    t_flush = 1'b0; t_rdy1 = 1'b0; t_rdy0 = 1'b1;
    set_req(BR_NE, 32'h10, 32'd1, 32'd2, 1'b1, 32'h6000);
    cycle();
    cycle();
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {63'b0, if1.out_valid}, 64'd0);
    chk("arst_p0_valid", {63'b0, if0.out_valid}, 64'd0);
    chk("arst_bc", {32'b0, bc1}, 64'd0);
    chk("arst_mc", {32'b0, mc1}, 64'd0);
    chk("arst_bc0", {56'b0, bc0}, 64'd0);
    for (int i = 0; i < N_BHT; i++) begin
      t_lookup = 32'(i) * 32'd4;
      #1;
      chk("arst_bht_p1", {63'b0, lt1}, 64'd0);
      chk("arst_bht_p0", {63'b0, lt0}, 64'd0);
    end
    model_reset();
    t_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    t_rdy1 = 1'b1;
    for (int n = 0; n < 40; n++) begin
      t_valid  = ($urandom_range(0, 3) != 0);
      t_sel    = br_sel_e'(3'($urandom_range(0, 7)));
      t_a      = pick_op();
      t_b      = pick_op();
      t_pc     = 32'($urandom_range(0, 31)) * 32'd4;
      t_lookup = t_pc;
      t_pred   = 1'($urandom_range(0, 1));
      t_target = $urandom;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
